// File: rtl/expr_sig_collector.sv
// Compacts a stream of DATA_W-bit expression results into a 32-bit signature
// and compares it with a golden value.
// Latency: sig_valid rises 3 cycles after the last accepted sample, or 3 cycles
// after start when num_samples is 0.
// Backpressure: in_ready is high only in RUN and depends on state alone. A sample
// presented while in_ready is low is neither consumed nor recorded.
//
// Ports:
//   clk, rst_n         - clock (rising edge) and asynchronous active-low reset
//   start, num_samples - begin a run of num_samples samples (IDLE/DONE only)
//   in_valid, in_ready - sample handshake; y_in is the sample data
//   expected_sig       - golden signature, sampled on the last FOLD cycle
//   busy, sig_valid    - busy in RUN/FOLD; sig_valid while in DONE
//   sig, match, count  - folded signature, golden compare, accepted sample count
module expr_sig_collector #(
   parameter int DATA_W = 90,
   parameter int CNT_W  = 16,
   parameter int SIG_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_samples,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] y_in,
   input  logic [SIG_W-1:0]  expected_sig,
   output logic              busy,
   output logic              sig_valid,
   output logic [SIG_W-1:0]  sig,
   output logic              match,
   output logic [CNT_W-1:0]  count
);

   // The MISR is zero-padded to three signature words before folding.
   localparam int FOLD_W = 3 * SIG_W;
   localparam int TAP_A  = 36;
   localparam int TAP_B  = 63;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [DATA_W-1:0] misr;
   logic [DATA_W-1:0] misr_step;
   logic [FOLD_W-1:0] misr_pad;
   logic [SIG_W-1:0]  acc;
   logic [SIG_W-1:0]  acc_step;
   logic [SIG_W-1:0]  fold_word;
   logic [1:0]        k;
   logic [CNT_W-1:0]  n_lat;
   logic              start_acc;
   logic              accept;
   logic              last_sample;

   // start is honoured only when no run is in progress.
   assign start_acc   = start && ((state == IDLE) || (state == DONE));
   // Uses the state directly rather than in_ready so the handshake term
   // stays a plain function of registered state and in_valid.
   assign accept      = in_valid && (state == RUN);
   assign last_sample = (count == (n_lat - CNT_W'(1)));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and state-decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      sig_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (num_samples == '0) ? FOLD : RUN;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && last_sample) begin
               state_nxt = FOLD;
            end
         end
         FOLD: begin
            busy = 1'b1;
            if (k == 2'd2) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            sig_valid = 1'b1;
            if (start) begin
               state_nxt = (num_samples == '0) ? FOLD : RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // MISR update: shift left, with the MSB feeding back into bit 0 and
   // into the taps at bits 36 and 63, then XOR in the new sample.
   // ------------------------------------------------------------------
   always_comb begin
      misr_step        = {misr[DATA_W-2:0], misr[DATA_W-1]} ^ y_in;
      misr_step[TAP_A] = misr_step[TAP_A] ^ misr[DATA_W-1];
      misr_step[TAP_B] = misr_step[TAP_B] ^ misr[DATA_W-1];
   end

   // ------------------------------------------------------------------
   // Fold: XOR the padded MISR one signature word per cycle, low word
   // first. The top word carries the MISR MSBs, with zeros above them.
   // ------------------------------------------------------------------
   assign misr_pad = FOLD_W'(misr);

   always_comb begin
      case (k)
         2'd0:    fold_word = misr_pad[SIG_W-1:0];
         2'd1:    fold_word = misr_pad[2*SIG_W-1:SIG_W];
         default: fold_word = misr_pad[3*SIG_W-1:2*SIG_W];
      endcase
      acc_step = acc ^ fold_word;
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misr  <= '0;
         acc   <= '0;
         k     <= 2'd0;
         count <= '0;
         n_lat <= '0;
         sig   <= '0;
         match <= 1'b0;
      end else begin
         if (start_acc) begin
            misr  <= '0;
            acc   <= '0;
            k     <= 2'd0;
            count <= '0;
            n_lat <= num_samples;
         end else if (accept) begin
            misr  <= misr_step;
            count <= count + CNT_W'(1);
         end else if (state == FOLD) begin
            acc <= acc_step;
            if (k == 2'd2) begin
               // The compare uses the final accumulator value, not the
               // registered copy, so sig and match update together.
               k     <= 2'd0;
               sig   <= acc_step;
               match <= (acc_step == expected_sig);
            end else begin
               k <= k + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_expr_sig_collector.sv
module tb_expr_sig_collector;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] num_samples;
   logic        in_valid;
   logic        in_ready;
   logic [89:0] y_in;
   logic [31:0] expected_sig;
   logic        busy;
   logic        sig_valid;
   logic [31:0] sig;
   logic        match;
   logic [15:0] count;

   expr_sig_collector #(.DATA_W(90), .CNT_W(16), .SIG_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .num_samples  (num_samples),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .y_in         (y_in),
      .expected_sig (expected_sig),
      .busy         (busy),
      .sig_valid    (sig_valid),
      .sig          (sig),
      .match        (match),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] sig;
      logic        match;
      logic [15:0] cnt;
      int          t;
   } exp_t;

   exp_t        sb[$];
   logic [89:0] ys[$];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: the MISR is a 90-bit vector that rotates left by one
   // each sample; when the bit leaving the top was 1 the taps at 36 and 63
   // are flipped. The signature XORs the three 32-bit words of the
   // zero-extended 96-bit value.
   function automatic logic [89:0] model_step(input logic [89:0] m, input logic [89:0] y);
      logic [89:0] r;
      r = (m << 1) | (m >> 89);
      if (m[89]) r = r ^ ((90'd1 << 36) | (90'd1 << 63));
      return r ^ y;
   endfunction

   function automatic logic [31:0] model_sig(input int n);
      logic [89:0] m;
      logic [95:0] p;
      m = '0;
      for (int i = 0; i < n; i++) m = model_step(m, ys[i]);
      p = {6'b0, m};
      return p[31:0] ^ p[63:32] ^ p[95:64];
   endfunction

   function automatic logic [89:0] rand90();
      logic [95:0] v;
      v = {$urandom, $urandom, $urandom};
      return v[89:0];
   endfunction

   // Monitor: each rising edge of sig_valid is matched against the oldest
   // outstanding expectation, including the cycle on which it should appear.
   logic sv_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n && sig_valid && !sv_prev) begin
         if (sb.size() == 0) begin
            check("unexpected_sig_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sig", sig, e.sig);
            check("match", match, e.match);
            check("count", count, e.cnt);
            check("sig_valid_latency_cycle", cyc, e.t);
         end
      end
      sv_prev = sig_valid;
   end

   // One collection run over ys[0..n-1]. vprob is the percentage chance that
   // in_valid is driven high in each RUN cycle. mid_start pulses start halfway
   // through RUN. abort applies reset on FOLD cycle k=1. use_const replaces
   // the model signature with the literal value want.
   task automatic run(input int n, input logic [31:0] es, input int vprob,
                      input bit mid_start, input bit abort,
                      input bit use_const, input logic [31:0] want);
      int          acc;
      int          budget;
      int          last;
      logic [31:0] s;
      exp_t        e;
      acc = 0;
      budget = 0;
      @(negedge clk);
      expected_sig = es;
      num_samples  = 16'(n);
      start        = 1'b1;
      in_valid     = $urandom_range(1);
      y_in         = rand90();
      @(negedge clk);
      start       = 1'b0;
      num_samples = 16'($urandom);
      while (acc < n && budget < 5000) begin
         check("in_ready_in_run", in_ready, 1);
         check("busy_in_run", busy, 1);
         in_valid = ($urandom_range(99) < vprob);
         y_in     = in_valid ? ys[acc] : rand90();
         start    = mid_start && (acc == n / 2);
         if (in_valid) acc++;
         budget++;
         @(negedge clk);
      end
      if (acc < n) check("run_budget_expired", acc, n);
      // Fold phase: a start pulse and stray in_valid must both be ignored.
      in_valid    = 1'b1;
      y_in        = rand90();
      start       = 1'b1;
      num_samples = 16'($urandom);
      last        = cyc;
      s           = use_const ? want : model_sig(n);
      if (!abort) begin
         e.sig   = s;
         e.match = (s == es);
         e.cnt   = 16'(n);
         e.t     = last + 3;
         sb.push_back(e);
      end
      for (int k = 0; k < 3; k++) begin
         if (abort && k == 1) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", busy, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_sig_valid", sig_valid, 0);
            check("rst_sig", sig, 0);
            check("rst_match", match, 0);
            check("rst_count", count, 0);
            @(negedge clk);
            rst_n    = 1'b1;
            start    = 1'b0;
            in_valid = 1'b0;
            return;
         end
         check("in_ready_in_fold", in_ready, 0);
         check("busy_in_fold", busy, 1);
         check("sig_valid_in_fold", sig_valid, 0);
         @(negedge clk);
         start    = 1'b0;
         in_valid = $urandom_range(1);
         y_in     = rand90();
      end
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("hold_sig", sig, s);
      check("hold_match", match, (s == es));
      check("hold_count", count, 16'(n));
      check("hold_sig_valid", sig_valid, 1);
      check("hold_in_ready", in_ready, 0);
   endtask

   initial begin
      logic [89:0] v;
      logic [31:0] es;
      int          n;
      rst_n        = 1'b0;
      start        = 1'b0;
      num_samples  = '0;
      in_valid     = 1'b0;
      y_in         = '0;
      expected_sig = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 0);
      check("reset_sig_valid", sig_valid, 0);
      check("reset_sig", sig, 0);
      check("reset_match", match, 0);
      check("reset_count", count, 0);
      rst_n    = 1'b1;
      // in_valid held with no run active must be ignored.
      in_valid = 1'b1;
      y_in     = rand90();
      repeat (2) @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      check("idle_count", count, 0);
      in_valid = 1'b0;

      // Single sample equal to 1.
      ys.delete();
      v = 90'd1;
      ys.push_back(v);
      run(1, 32'h0000_0001, 100, 0, 0, 1, 32'h0000_0001);

      // Single sample with only the MSB set.
      ys.delete();
      v = 90'd1 << 89;
      ys.push_back(v);
      run(1, 32'h0, 100, 0, 0, 1, 32'h0200_0000);

      // MSB sample followed by zero exercises the feedback taps.
      ys.delete();
      v = 90'd1 << 89;
      ys.push_back(v);
      v = '0;
      ys.push_back(v);
      run(2, 32'h8000_0011, 60, 0, 0, 1, 32'h8000_0011);

      // Zero-length runs.
      ys.delete();
      run(0, 32'h0, 100, 0, 0, 1, 32'h0);
      run(0, 32'h1234_5678, 100, 0, 0, 1, 32'h0);

      // 100 all-ones samples with random in_valid gaps and a mid-run start.
      ys.delete();
      v = '1;
      for (int i = 0; i < 100; i++) ys.push_back(v);
      run(100, model_sig(100), 50, 1, 0, 0, 32'h0);

      // Random runs.
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(12, 1);
         ys.delete();
         for (int i = 0; i < n; i++) ys.push_back(rand90());
         es = ($urandom_range(1) == 1) ? model_sig(n) : $urandom;
         run(n, es, 70, 0, 0, 0, 32'h0);
      end

      // Reset in the middle of FOLD, then the same data again.
      ys.delete();
      for (int i = 0; i < 3; i++) ys.push_back(rand90());
      es = model_sig(3);
      run(3, es, 100, 0, 1, 0, 32'h0);
      check("post_reset_sig", sig, 0);
      check("post_reset_sig_valid", sig_valid, 0);
      check("post_reset_in_ready", in_ready, 0);
      run(3, es, 80, 0, 0, 0, 32'h0);

      repeat (2) @(negedge clk);
      check("final_scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout actual=%0d required=finished", cyc);
      $fatal(1, "watchdog");
   end

endmodule
